// File: rtl/btn_input_bank_pkg.sv
// Shared types and 50 MHz timing defaults for the push-button conditioner.
package btn_input_bank_pkg;

    localparam int DEF_N_BTN             = 4;
    localparam int DEF_DEBOUNCE_CYCLES   = 50000;      // 1 ms @ 50 MHz
    localparam int DEF_LONG_PRESS_CYCLES = 150000000;  // 3 s @ 50 MHz

    typedef enum logic [1:0] {
        BTN_IDLE      = 2'd0,
        BTN_HELD      = 2'd1,
        BTN_LONG_HELD = 2'd2
    } btn_state_t;

    // Per-channel outputs, all active-high
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic shrt;
        logic lng;
    } btn_evt_t;

endpackage

// File: rtl/btn_input_bank_if.sv
// Button bank bus: raw pins in, debounced level and event pulses out.
interface btn_input_bank_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_short;
    logic [N_BTN-1:0] btn_long;

    // master: the conditioner bank; slave: pins driver / event consumer
    modport master (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_short, btn_long
    );
    modport slave (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_short, btn_long
    );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop sync, polarity normalise, debounce, press/release/short/long FSM.
// Latency: level and press/release follow a steady raw change by DEBOUNCE_CYCLES+2 edges.
// Backpressure: none; events are free-running single-cycle pulses.
module btn_channel
    import btn_input_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     raw,
    output btn_evt_t evt
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LH_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LH_W-1:0] HOLD_MAX = LH_W'(LONG_PRESS_CYCLES);
    localparam logic [LH_W-1:0] HOLD_PRE = LH_W'(LONG_PRESS_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic [LH_W-1:0] hold_cnt;
    btn_state_t      state;

    logic norm;
    logic rise;
    logic fall;

    assign norm = sync2 ^ ACTIVE_LOW;
    // evt.level is stable delayed one edge, so edges of stable become registered pulses
    assign rise = stable & ~evt.level;
    assign fall = ~stable & evt.level;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= ACTIVE_LOW;
            sync2    <= ACTIVE_LOW;
            stable   <= 1'b0;
            db_cnt   <= '0;
            hold_cnt <= '0;
            state    <= BTN_IDLE;
            evt      <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;

            if (norm == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= norm;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            evt.level <= stable;
            evt.press <= 1'b0;
            evt.rel   <= 1'b0;
            evt.shrt  <= 1'b0;
            evt.lng   <= 1'b0;

            // Release is tested before the long-press threshold, so it wins a tie
            if (rise) begin
                evt.press <= 1'b1;
                hold_cnt  <= '0;
                state     <= BTN_HELD;
            end else if (fall) begin
                evt.rel   <= 1'b1;
                evt.shrt  <= (state == BTN_HELD);
                hold_cnt  <= '0;
                state     <= BTN_IDLE;
            end else if (evt.level) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                case (state)
                    BTN_HELD: begin
                        if (hold_cnt == HOLD_PRE) begin
                            evt.lng <= 1'b1;
                            state   <= BTN_LONG_HELD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_input_bank.sv
// N-channel push-button conditioner: one btn_channel per pin, vectors sliced per bit.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampling of a steady raw change.
// Backpressure: none; all outputs are active-high levels or 1-cycle pulses.
module btn_input_bank
    import btn_input_bank_pkg::*;
#(
    parameter int               N_BTN             = DEF_N_BTN,
    parameter int               DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int               LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK   = {N_BTN{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    btn_input_bank_if.master  bus
);
    btn_evt_t evt [N_BTN];

    for (genvar i = 0; i < N_BTN; i++) begin : gen_ch
        btn_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .ACTIVE_LOW        (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.btn_raw[i]),
            .evt   (evt[i])
        );

        assign bus.btn_level[i]   = evt[i].level;
        assign bus.btn_press[i]   = evt[i].press;
        assign bus.btn_release[i] = evt[i].rel;
        assign bus.btn_short[i]   = evt[i].shrt;
        assign bus.btn_long[i]    = evt[i].lng;
    end

endmodule
